conv_scheduler: RTL and testbench

Sequencing controller for the convolution operator's PE array. After a load_done pulse it loads kernel weight rows, then sweeps every output pixel of a square, stride-1, no-padding convolution. For each pixel it issues ifmap buffer reads, PE enables and partial-sum clears, waits for the array pipeline to drain, and presents the result through a valid/ready handshake. It sits between the buffer/load logic and the PE array inside the convolution operator.

---
 rtl/conv_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_conv_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_scheduler.sv
// Sequencing controller for the convolution PE array: loads kernel rows, then sweeps
// every output pixel issuing ifmap reads / PE enables, drains the pipe and hands off results.
module conv_scheduler #(
  parameter int unsigned NUM_ROW     = 7,
  parameter int unsigned NUM_COL     = 7,
  parameter int unsigned BUFFER_SIZE = 512,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned PIPE_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            kernel_size,
  input  logic [7:0]            ifmap_size,
  input  logic                  load_done,
  input  logic                  ofmap_ready,
  output logic                  weight_rd_en,
  output logic [7:0]            weight_rd_addr,
  output logic                  ifmap_rd_en,
  output logic [ADDR_WIDTH-1:0] ifmap_rd_addr,
  output logic                  pe_en,
  output logic                  psum_clear,
  output logic                  ofmap_valid,
  output logic                  ofmap_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_cfg
);

  localparam int unsigned KMAX = (NUM_ROW < NUM_COL) ? NUM_ROW : NUM_COL;
  localparam int unsigned CW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, OUT, FIN} state_t;

  state_t          state, state_n;
  logic [7:0]      k_q, k_n, w_q, w_n, o_q, o_n;
  logic [7:0]      ky_q, ky_n, ox_q, ox_n, oy_q, oy_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [15:0]     area, addr_full;
  logic            cfg_bad, pix_last;
  logic            weight_rd_en_n, ifmap_rd_en_n, psum_clear_n;
  logic            ofmap_valid_n, ofmap_last_n, busy_n, done_n, err_cfg_n;
  logic [7:0]      weight_rd_addr_n;
  logic [ADDR_WIDTH-1:0] ifmap_rd_addr_n;

  // Configuration check on the raw inputs, evaluated while a load_done is offered
  always_comb begin
    area    = 16'(ifmap_size) * 16'(ifmap_size);
    cfg_bad = (kernel_size == 8'd0) || (32'(kernel_size) > KMAX) ||
              (kernel_size > ifmap_size) || (32'(area) > BUFFER_SIZE);
  end

  assign pix_last = (oy_q == o_q - 8'd1) && (ox_q == o_q - 8'd1);

  // Next-state and counter update
  always_comb begin
    state_n   = state;
    k_n       = k_q;
    w_n       = w_q;
    o_n       = o_q;
    ky_n      = ky_q;
    ox_n      = ox_q;
    oy_n      = oy_q;
    cnt_n     = cnt_q;
    err_cfg_n = 1'b0;
    case (state)
      IDLE: begin
        if (load_done) begin
          if (cfg_bad) begin
            err_cfg_n = 1'b1;
          end else begin
            state_n = LOAD_W;
            k_n     = kernel_size;
            w_n     = ifmap_size;
            o_n     = ifmap_size - kernel_size + 8'd1;
            ky_n    = 8'd0;
          end
        end
      end
      LOAD_W: begin
        if (ky_q == k_q - 8'd1) begin
          state_n = COMPUTE;
          ky_n    = 8'd0;
          ox_n    = 8'd0;
          oy_n    = 8'd0;
        end else begin
          ky_n = ky_q + 8'd1;
        end
      end
      COMPUTE: begin
        if (ky_q == k_q - 8'd1) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          ky_n = ky_q + 8'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(PIPE_LAT - 1)) state_n = OUT;
        else                            cnt_n   = cnt_q + CW'(1);
      end
      OUT: begin
        if (ofmap_ready) begin
          if (pix_last) begin
            state_n = FIN;
          end else begin
            state_n = COMPUTE;
            ky_n    = 8'd0;
            if (ox_q == o_q - 8'd1) begin
              ox_n = 8'd0;
              oy_n = oy_q + 8'd1;
            end else begin
              ox_n = ox_q + 8'd1;
            end
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    addr_full        = (16'(oy_n) + 16'(ky_n)) * 16'(w_n) + 16'(ox_n);
    weight_rd_en_n   = (state_n == LOAD_W);
    weight_rd_addr_n = (state_n == LOAD_W) ? ky_n : 8'd0;
    ifmap_rd_en_n    = (state_n == COMPUTE);
    ifmap_rd_addr_n  = (state_n == COMPUTE) ? ADDR_WIDTH'(addr_full) : '0;
    psum_clear_n     = (state_n == COMPUTE) && (ky_n == 8'd0);
    ofmap_valid_n    = (state_n == OUT);
    ofmap_last_n     = (state_n == OUT) && (oy_n == o_n - 8'd1) && (ox_n == o_n - 8'd1);
    busy_n           = (state_n != IDLE);
    done_n           = (state_n == FIN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      k_q            <= '0;
      w_q            <= '0;
      o_q            <= '0;
      ky_q           <= '0;
      ox_q           <= '0;
      oy_q           <= '0;
      cnt_q          <= '0;
      weight_rd_en   <= 1'b0;
      weight_rd_addr <= '0;
      ifmap_rd_en    <= 1'b0;
      ifmap_rd_addr  <= '0;
      pe_en          <= 1'b0;
      psum_clear     <= 1'b0;
      ofmap_valid    <= 1'b0;
      ofmap_last     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_cfg        <= 1'b0;
    end else begin
      state          <= state_n;
      k_q            <= k_n;
      w_q            <= w_n;
      o_q            <= o_n;
      ky_q           <= ky_n;
      ox_q           <= ox_n;
      oy_q           <= oy_n;
      cnt_q          <= cnt_n;
      weight_rd_en   <= weight_rd_en_n;
      weight_rd_addr <= weight_rd_addr_n;
      ifmap_rd_en    <= ifmap_rd_en_n;
      ifmap_rd_addr  <= ifmap_rd_addr_n;
      pe_en          <= ifmap_rd_en_n;
      psum_clear     <= psum_clear_n;
      ofmap_valid    <= ofmap_valid_n;
      ofmap_last     <= ofmap_last_n;
      busy           <= busy_n;
      done           <= done_n;
      err_cfg        <= err_cfg_n;
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler: expected reads/results queued at job start,
// popped and compared by a negedge monitor as the DUT produces them.
module tb_conv_scheduler;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] kernel_size = 8'd0;
  logic [7:0] ifmap_size = 8'd0;
  logic       load_done = 1'b0;
  logic       ofmap_ready = 1'b1;
  logic       weight_rd_en, ifmap_rd_en, pe_en, psum_clear;
  logic       ofmap_valid, ofmap_last, busy, done, err_cfg;
  logic [7:0] weight_rd_addr;
  logic [8:0] ifmap_rd_addr;

  conv_scheduler dut (
    .clk(clk), .rstn(rstn), .kernel_size(kernel_size), .ifmap_size(ifmap_size),
    .load_done(load_done), .ofmap_ready(ofmap_ready),
    .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr),
    .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_addr(ifmap_rd_addr),
    .pe_en(pe_en), .psum_clear(psum_clear), .ofmap_valid(ofmap_valid),
    .ofmap_last(ofmap_last), .busy(busy), .done(done), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int qw[$];
  int qr[$];
  bit qo[$];
  int hs_cnt = 0, done_cnt = 0, busy_cnt = 0, last_len = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({weight_rd_en, weight_rd_addr, ifmap_rd_en, ifmap_rd_addr, pe_en, psum_clear,
                 ofmap_valid, ofmap_last, busy, done, err_cfg});
  endfunction

  // Reference sequence of a job, built straight from the sweep definition
  task automatic push_job(input int k, input int w);
    int o;
    o = w - k + 1;
    for (int ky = 0; ky < k; ky++) qw.push_back(ky);
    for (int oy = 0; oy < o; oy++)
      for (int ox = 0; ox < o; ox++) begin
        for (int ky = 0; ky < k; ky++)
          qr.push_back((((oy + ky) * w + ox) << 1) | (ky == 0 ? 1 : 0));
        qo.push_back((oy == o - 1) && (ox == o - 1));
      end
  endtask

  task automatic start(input int k, input int w);
    push_job(k, w);
    @(posedge clk); #1;
    kernel_size = 8'(k);
    ifmap_size  = 8'(w);
    load_done   = 1'b1;
    @(posedge clk); #1;
    load_done   = 1'b0;
    kernel_size = 8'($urandom);
    ifmap_size  = 8'($urandom);
  endtask

  task automatic wait_done(input int exp_len, input int d0, input bit poke);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 3000);
    check("done_seen", int'(done), 1);
    if (poke) begin
      kernel_size = 8'd1;
      ifmap_size  = 8'd1;
      load_done   = 1'b1;
    end
    @(posedge clk); #1;
    load_done = 1'b0;
    @(negedge clk); #1;
    check("busy_after_done", int'(busy), 0);
    check("busy_length", last_len, exp_len);
    check("done_count", done_cnt - d0, 1);
    check("queues_drained", qw.size() + qr.size() + qo.size(), 0);
  endtask

  task automatic reject(input int k, input int w);
    @(posedge clk); #1;
    kernel_size = 8'(k);
    ifmap_size  = 8'(w);
    load_done   = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0;
    @(negedge clk);
    check("err_pulse", int'(err_cfg), 1);
    check("err_busy", int'({busy, weight_rd_en, ifmap_rd_en}), 0);
    @(negedge clk);
    check("err_one_cycle", int'(err_cfg), 0);
    check("err_busy_after", int'({busy, weight_rd_en, ifmap_rd_en}), 0);
  endtask

  // Monitor: pops scoreboard entries whenever the DUT issues a read or completes a handshake
  always @(negedge clk) begin
    if (rstn) begin
      if (weight_rd_en) begin
        if (qw.size() == 0) check("weight_unexpected", int'(weight_rd_en), 0);
        else check("weight_addr", int'(weight_rd_addr), qw.pop_front());
      end
      if (ifmap_rd_en || pe_en) begin
        check("pe_en_match", int'(pe_en), int'(ifmap_rd_en));
        if (qr.size() == 0) check("ifmap_unexpected", int'(ifmap_rd_en), 0);
        else begin
          int e;
          e = qr.pop_front();
          check("ifmap_addr", int'(ifmap_rd_addr), e >> 1);
          check("psum_clear", int'(psum_clear), e & 1);
        end
      end else if (psum_clear) begin
        check("psum_clear_idle", int'(psum_clear), 0);
      end
      if (ofmap_last && !ofmap_valid) check("last_without_valid", int'(ofmap_last), 0);
      if (ofmap_valid && ofmap_ready) begin
        hs_cnt++;
        if (qo.size() == 0) check("ofmap_unexpected", int'(ofmap_valid), 0);
        else check("ofmap_last", int'(ofmap_last), int'(qo.pop_front()));
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      else if (busy_cnt != 0) begin
        last_len = busy_cnt;
        busy_cnt = 0;
      end
    end
  end

  initial begin
    int d0, h0, n;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Nominal 3x3 kernel over 5x5 ifmap
    d0 = done_cnt;
    start(3, 5);
    wait_done(76, d0, 1'b0);

    // Degenerate 1x1 job
    d0 = done_cnt;
    start(1, 1);
    wait_done(8, d0, 1'b0);

    // Downstream stall at the first result
    ofmap_ready = 1'b0;
    d0 = done_cnt;
    start(3, 5);
    n = 0;
    do begin @(negedge clk); n++; end while (ofmap_valid !== 1'b1 && n < 500);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_valid", int'(ofmap_valid), 1);
      check("stall_no_read", int'(ifmap_rd_en), 0);
    end
    @(posedge clk); #1;
    ofmap_ready = 1'b1;
    wait_done(81, d0, 1'b0);

    // Rejected configurations
    reject(8, 10);
    reject(0, 5);
    reject(6, 5);
    reject(3, 23);

    // Reset during the fourth pixel's compute phase
    d0 = done_cnt;
    h0 = hs_cnt;
    start(3, 5);
    n = 0;
    do begin @(negedge clk); n++; end
      while (!((hs_cnt - h0) >= 3 && ifmap_rd_en === 1'b1) && n < 500);
    check("reset_point_reached", int'(ifmap_rd_en), 1);
    #2 rstn = 1'b0;
    #1 check("reset_mid_job_outputs", all_outs(), 0);
    qw.delete();
    qr.delete();
    qo.delete();
    repeat (3) @(negedge clk);
    check("reset_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    d0 = done_cnt;
    start(3, 5);
    wait_done(76, d0, 1'b0);

    // Stray load_done pulses mid-job and coincident with done
    d0 = done_cnt;
    start(3, 5);
    repeat (20) @(posedge clk);
    #1;
    kernel_size = 8'd1;
    ifmap_size  = 8'd1;
    load_done   = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0;
    wait_done(76, d0, 1'b1);
    repeat (3) @(negedge clk);
    check("idle_after_coincident", int'({busy, err_cfg, weight_rd_en}), 0);
    check("single_done", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
